vga_out_stage: RTL and testbench
================================

# vga_out_stage

Final video stage between the XVGA timing generator / mole pixel mux and the board VGA connector. Delays the raw sync and blank signals to line up with the pixel stream, which arrives late because of sprite ROM pipelining. Truncates 24-bit pixels to 4-bit-per-channel DAC outputs and forces black during blanking. Also runs a frame-synchronous full-screen flash effect (hit/miss feedback) and a free-running frame counter.

## Interface
Parameters:
- SYNC_DELAY, 3: cycles by which input pixel lags hcount/vcount/sync/blank; legal range 1–15.
- FLASH_FRAMES, 8: number of frames a flash lasts; legal range 1–255.

Ports:
- vclock  in  1  pixel clock, 65 MHz XVGA.
- reset  in  1  synchronous, active-high.
- hcount  in  11  horizontal pixel index from the timing generator.
- vcount  in  10  line index from the timing generator.
- hsync_in  in  1  active-low hsync from the timing generator.
- vsync_in  in  1  active-low vsync from the timing generator.
- blank_in  in  1  blank from the timing generator; 1 = not visible.
- pixel  in  24  {R8,G8,B8} from the mole mux, lagging hcount by SYNC_DELAY.
- flash_req  in  1  single-cycle request to start a flash.
- flash_color  in  2  flash color, sampled with flash_req: 0 = red F00, 1 = green 0F0, 2 = white FFF, 3 = black 000.
- vga_r, vga_g, vga_b  out  4 each  DAC outputs.
- vga_hs, vga_vs  out  1 each  active-low syncs to the connector.
- frame_count  out  16  number of completed frames.
- flash_active  out  1  high while in FLASHING.

## Operation
- Sync alignment:
  - hsync_in, vsync_in and blank_in each pass through a SYNC_DELAY-deep shift register, then one output register.
  - pixel passes through only the output register.
  - Result: hsync/vsync/blank for a screen position leave the block on the same cycle as that position's pixel.
- Channel extraction: r = pixel[23:20], g = pixel[15:12], b = pixel[7:4]. The low nibbles are discarded.
- Blanking: when the delayed blank is 1, vga_r, vga_g and vga_b are all registered as 0, regardless of any flash.
- Frame tick:
  - One-cycle internal pulse when the input hcount == 0 and vcount == 768, i.e. the first cycle of vertical blank.
  - All state changes happen on this pulse. No visible pixel in flight is affected, because SYNC_DELAY < 38 × 1344.
- frame_count: increments on every frame tick and wraps from FFFF to 0000.
- Flash state machine, 2-bit state register:
  - IDLE: on flash_req, latch flash_color and go to ARMED.
  - ARMED: on frame tick, load the frame counter with FLASH_FRAMES and go to FLASHING.
  - FLASHING: on frame tick, decrement the counter. If the counter was 1, go to IDLE instead.
  - Retrigger: flash_req in ARMED or FLASHING re-latches the color and goes to ARMED. A FLASHING frame keeps displaying until the next tick, which restarts a full FLASH_FRAMES.
  - Simultaneous events: if flash_req and a frame tick land on the same cycle, flash_req wins and the state is ARMED.
- Flash blend: active in FLASHING on visible pixels only.
  - Each channel out = p[3:1] + c[3:1], where p is the extracted nibble and c is the flash color nibble.
  - The sum is 4-bit with no overflow; the maximum is 7 + 7 = 14.
- Reset values:
  - vga_r, vga_g, vga_b = 0; vga_hs = 1; vga_vs = 1.
  - frame_count = 0; flash_active = 0; state = IDLE; frame counter = 0; latched color = 0.
  - All delay-line taps: hsync = 1, vsync = 1, blank = 1.
- Reset mid-flash returns to IDLE immediately. Outputs are black with inactive syncs until valid data fills the delay lines.

## Timing
- Latency:
  - hsync_in, vsync_in, blank_in → output: SYNC_DELAY + 1 cycles.
  - pixel → output: 1 cycle.
- flash_active rises 1 cycle after the frame tick that follows the request. It falls 1 cycle after the FLASH_FRAMES-th subsequent tick.
- frame_count updates 1 cycle after the tick.
- There is no backpressure. flash_req is a fire-and-forget pulse; holding it high just keeps re-arming.

## Test plan
- Alignment:
  - Stimulus: SYNC_DELAY = 3; hsync_in falls at hcount = 1047; pixel = 24'hA5C3E1 presented 3 cycles after hcount = 10.
  - Required: vga_hs falls 4 cycles after hcount = 1047 enters. The pixel appears 1 cycle later as r = A, g = C, b = E.
- Blanking: pixel = FFFFFF with delayed blank = 1 → vga_r/g/b = 0 on every blank cycle.
- Flash:
  - Stimulus: FLASH_FRAMES = 2; flash_req with color 0 (red) mid-frame; pixel = 808080.
  - Required: no change until the tick. Then for 2 frames visible output = r 4+7 = B, g 4, b 4. Then back to 8,8,8; flash_active high for exactly 2 frame periods.
- Retrigger: second flash_req with color 1 during frame 1 of a flash → the current frame finishes red, then a full FLASH_FRAMES of green (g = B, r = 4).
- Frame counter wrap: force 200 frames from reset → frame_count = 200. Preload via 65536 ticks (accelerated bench) → wraps to 0.
- Reset mid-flash: assert reset during FLASHING → next cycle flash_active = 0, vga_hs = vga_vs = 1, RGB = 0, frame_count = 0.

Source files
------------

// File: rtl/vga_out_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_out_stage
//
// Last stage in front of the VGA connector. The pixel stream reaches this block
// SYNC_DELAY cycles after the matching hcount/vcount/sync/blank, because the
// sprite ROMs add pipeline stages. This block delays the syncs and blank so
// that they leave together with their pixel. It also:
//   - truncates each 8-bit colour channel to a 4-bit DAC value,
//   - forces black during blanking,
//   - runs a frame-synchronous full-screen flash (hit/miss feedback),
//   - counts completed frames.
//
// Parameters
//   SYNC_DELAY    cycles by which pixel lags the timing signals (1..15)
//   FLASH_FRAMES  number of frames a flash lasts (1..255)
//
// Ports
//   vclock        pixel clock (65 MHz XVGA)
//   reset         synchronous, active-high
//   hcount        horizontal pixel index, 11 bits
//   vcount        line index, 10 bits
//   hsync_in      active-low hsync from the timing generator
//   vsync_in      active-low vsync from the timing generator
//   blank_in      1 = position not visible
//   pixel         {R8,G8,B8}, SYNC_DELAY cycles behind hcount
//   flash_req     one-cycle request to start a flash
//   flash_color   0 red, 1 green, 2 white, 3 black; sampled with flash_req
//   vga_r/g/b     4-bit DAC outputs
//   vga_hs/vs     active-low syncs to the connector
//   frame_count   completed frames, wraps at 16 bits
//   flash_active  high while the flash machine is in FLASHING
// -----------------------------------------------------------------------------
module vga_out_stage #(
    parameter int SYNC_DELAY   = 3,
    parameter int FLASH_FRAMES = 8
) (
    input  logic        vclock,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic [23:0] pixel,
    input  logic        flash_req,
    input  logic [1:0]  flash_color,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [15:0] frame_count,
    output logic        flash_active
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FLASHING = 2'd2
    } flash_state_t;

    // First cycle of vertical blank. Nothing visible is in flight here, so
    // every flash/display change made on this cycle is invisible on screen.
    logic frame_tick;
    assign frame_tick = (hcount == 11'd0) && (vcount == 10'd768);

    // Flash colour decode to 12-bit {R4,G4,B4}.
    function automatic logic [11:0] flash_rgb(input logic [1:0] sel);
        logic [11:0] rgb;
        case (sel)
            2'd0:    rgb = 12'hF00;
            2'd1:    rgb = 12'h0F0;
            2'd2:    rgb = 12'hFFF;
            default: rgb = 12'h000;
        endcase
        return rgb;
    endfunction

    // -------------------------------------------------------------------------
    // Sync/blank delay line. Each tap holds {blank, vsync, hsync}. Reset fills
    // it with "inactive sync, blanked" so the screen stays black until real
    // timing data has walked through.
    // -------------------------------------------------------------------------
    logic [2:0] sync_dly_reg [SYNC_DELAY];

    always_ff @(posedge vclock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_DELAY; i++) begin
                sync_dly_reg[i] <= 3'b111;
            end
        end else begin
            for (int i = SYNC_DELAY - 1; i > 0; i--) begin
                sync_dly_reg[i] <= sync_dly_reg[i - 1];
            end
            sync_dly_reg[0] <= {blank_in, vsync_in, hsync_in};
        end
    end

    logic hs_dly;
    logic vs_dly;
    logic blank_dly;
    assign hs_dly    = sync_dly_reg[SYNC_DELAY - 1][0];
    assign vs_dly    = sync_dly_reg[SYNC_DELAY - 1][1];
    assign blank_dly = sync_dly_reg[SYNC_DELAY - 1][2];

    // -------------------------------------------------------------------------
    // Flash state machine.
    //
    // The display side (disp_flash_reg/disp_color_reg) only changes on a frame
    // tick, while the request side (state/color) reacts at once. This is what
    // lets a retriggered flash finish its current frame in the old colour even
    // though the machine has already gone back to ARMED.
    // -------------------------------------------------------------------------
    flash_state_t state_reg;
    logic [7:0]   frames_left_reg;
    logic [1:0]   color_reg;
    logic         disp_flash_reg;
    logic [1:0]   disp_color_reg;

    always_ff @(posedge vclock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            frames_left_reg <= 8'd0;
            color_reg       <= 2'd0;
            disp_flash_reg  <= 1'b0;
            disp_color_reg  <= 2'd0;
            flash_active    <= 1'b0;
            frame_count     <= 16'd0;
        end else begin
            if (frame_tick) begin
                frame_count <= frame_count + 16'd1;
            end

            if (flash_req) begin
                // A request always wins, even against a tick on the same cycle.
                state_reg    <= ST_ARMED;
                color_reg    <= flash_color;
                flash_active <= 1'b0;
                if (frame_tick) begin
                    disp_flash_reg <= 1'b0;
                end
            end else if (frame_tick) begin
                case (state_reg)
                    ST_ARMED: begin
                        state_reg       <= ST_FLASHING;
                        frames_left_reg <= 8'(FLASH_FRAMES);
                        flash_active    <= 1'b1;
                        disp_flash_reg  <= 1'b1;
                        disp_color_reg  <= color_reg;
                    end
                    ST_FLASHING: begin
                        if (frames_left_reg == 8'd1) begin
                            state_reg       <= ST_IDLE;
                            frames_left_reg <= 8'd0;
                            flash_active    <= 1'b0;
                            disp_flash_reg  <= 1'b0;
                        end else begin
                            frames_left_reg <= frames_left_reg - 8'd1;
                        end
                    end
                    ST_IDLE: begin
                        disp_flash_reg <= 1'b0;
                    end
                    default: begin
                        state_reg      <= ST_IDLE;
                        flash_active   <= 1'b0;
                        disp_flash_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel extraction and flash blend. Channel 0 = R, 1 = G, 2 = B.
    // Blend adds the top three bits of the pixel nibble and of the flash
    // nibble; 7 + 7 = 14 is the maximum, so the 4-bit sum cannot overflow.
    // -------------------------------------------------------------------------
    logic [11:0] disp_rgb;
    logic [3:0]  chan_next [3];

    assign disp_rgb = flash_rgb(disp_color_reg);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [3:0] pix_nib;
            logic [3:0] col_nib;
            logic [3:0] blend;

            assign pix_nib = pixel[23 - 8*gi -: 4];
            assign col_nib = disp_rgb[11 - 4*gi -: 4];
            assign blend   = {1'b0, pix_nib[3:1]} + {1'b0, col_nib[3:1]};

            assign chan_next[gi] = blank_dly      ? 4'd0  :
                                   disp_flash_reg ? blend : pix_nib;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output register: syncs come from the end of the delay line, the pixel
    // directly from its input, so both describe the same screen position.
    // -------------------------------------------------------------------------
    always_ff @(posedge vclock) begin
        if (reset) begin
            vga_r  <= 4'd0;
            vga_g  <= 4'd0;
            vga_b  <= 4'd0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else begin
            vga_r  <= chan_next[0];
            vga_g  <= chan_next[1];
            vga_b  <= chan_next[2];
            vga_hs <= hs_dly;
            vga_vs <= vs_dly;
        end
    end

endmodule

// File: tb/tb_vga_out_stage.sv
`timescale 1ns/1ps
// Self-checking bench for vga_out_stage. A behavioural model (queues for the
// sync delay, plain counters for the flash) predicts every output on every
// cycle; directed steps add fixed expected values from the test plan.
module tb_vga_out_stage;

    localparam int D  = 3;   // SYNC_DELAY
    localparam int FF = 2;   // FLASH_FRAMES
    localparam int FL = 30;  // cycles per synthetic frame

    logic        vclock = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hcount = 11'd0;
    logic [9:0]  vcount = 10'd0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        blank_in = 1'b1;
    logic [23:0] pixel = 24'd0;
    logic        flash_req = 1'b0;
    logic [1:0]  flash_color = 2'd0;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs;
    logic [15:0] frame_count;
    logic        flash_active;

    always #5 vclock = ~vclock;

    vga_out_stage #(.SYNC_DELAY(D), .FLASH_FRAMES(FF)) dut (
        .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .pixel(pixel), .flash_req(flash_req), .flash_color(flash_color),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs),
        .frame_count(frame_count), .flash_active(flash_active)
    );

    int checks = 0;
    int errors = 0;
    int fa_cycles = 0;

    // ---------------- reference model state ----------------
    bit         hs_q[$];
    bit         vs_q[$];
    bit         bl_q[$];
    bit         pending;       // request seen, waiting for the next frame
    int         frames_left;   // >0 means flashing
    logic [1:0] req_color;
    bit         show;          // flash visible in the current frame
    logic [1:0] show_color;
    int         fc;
    logic [3:0] er, eg, eb;
    logic       ehs, evs, efa;

    function automatic logic [11:0] flash_rgb(input logic [1:0] c);
        case (c)
            2'd0:    return 12'hF00;
            2'd1:    return 12'h0F0;
            2'd2:    return 12'hFFF;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [3:0] out_nib(input logic [3:0] p, input logic [3:0] c, input bit fl);
        int s;
        if (!fl) return p;
        s = int'(p) / 2 + int'(c) / 2;
        return s[3:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hs_q = {}; vs_q = {}; bl_q = {};
        repeat (D) begin
            hs_q.push_back(1'b1); vs_q.push_back(1'b1); bl_q.push_back(1'b1);
        end
        pending = 0; frames_left = 0; req_color = 2'd0;
        show = 0; show_color = 2'd0; fc = 0;
        er = 4'd0; eg = 4'd0; eb = 4'd0; ehs = 1'b1; evs = 1'b1; efa = 1'b0;
    endtask

    // One clock: update the model with the inputs sampled at this edge, then
    // compare every output 1 ns later.
    task automatic cycle();
        bit          bd;
        bit          tk;
        logic [11:0] cc;
        @(posedge vclock);
        if (reset) begin
            model_reset();
        end else begin
            ehs = hs_q.pop_front(); hs_q.push_back(hsync_in);
            evs = vs_q.pop_front(); vs_q.push_back(vsync_in);
            bd  = bl_q.pop_front(); bl_q.push_back(blank_in);
            cc  = flash_rgb(show_color);
            if (bd) begin
                er = 4'd0; eg = 4'd0; eb = 4'd0;
            end else begin
                er = out_nib(pixel[23:20], cc[11:8], show);
                eg = out_nib(pixel[15:12], cc[7:4], show);
                eb = out_nib(pixel[7:4], cc[3:0], show);
            end
            tk = (hcount == 11'd0) && (vcount == 10'd768);
            if (flash_req) begin
                pending = 1; req_color = flash_color; frames_left = 0;
            end else if (tk) begin
                if (pending) begin
                    pending = 0; frames_left = FF;
                end else if (frames_left > 0) begin
                    frames_left--;
                end
            end
            if (tk) begin
                show = (frames_left > 0);
                show_color = req_color;
                fc = (fc + 1) % 65536;
            end
            efa = (frames_left > 0);
        end
        #1;
        chk("model_r", 32'(vga_r), 32'(er));
        chk("model_g", 32'(vga_g), 32'(eg));
        chk("model_b", 32'(vga_b), 32'(eb));
        chk("model_hs", 32'(vga_hs), 32'(ehs));
        chk("model_vs", 32'(vga_vs), 32'(evs));
        chk("model_fa", 32'(flash_active), 32'(efa));
        chk("model_fc", 32'(frame_count), 32'(fc));
        if (flash_active === 1'b1) fa_cycles++;
    endtask

    task automatic drive(input logic [10:0] hc, input logic [9:0] vc, input logic hs,
                         input logic vs, input logic bl, input logic [23:0] px,
                         input logic rq, input logic [1:0] col);
        hcount = hc; vcount = vc; hsync_in = hs; vsync_in = vs; blank_in = bl;
        pixel = px; flash_req = rq; flash_color = col;
        cycle();
    endtask

    // Synthetic frame: cycle 0 is the frame tick, a few blank cycles follow,
    // the rest is visible with a constant pixel. Optional flash_req at req_at.
    task automatic frame(input string tag, input int req_at, input logic [1:0] col,
                         input logic [23:0] px, input logic [3:0] xr, input logic [3:0] xg,
                         input logic [3:0] xb, input logic xfa);
        for (int i = 0; i < FL; i++) begin
            logic bl;
            bl = (i < D + 2);
            drive((i == 0) ? 11'd0 : 11'(i), (i == 0) ? 10'd768 : (bl ? 10'd769 : 10'd5),
                  (i % 10) != 9, !(i == 1 || i == 2), bl, px, i == req_at, col);
            if (i >= 2 * D + 2) begin
                chk({tag, "_r"}, 32'(vga_r), 32'(xr));
                chk({tag, "_g"}, 32'(vga_g), 32'(xg));
                chk({tag, "_b"}, 32'(vga_b), 32'(xb));
            end
            if (req_at < 0 || i < req_at) chk({tag, "_fa"}, 32'(flash_active), 32'(xfa));
        end
        $display("frame %s: req_at=%0d out=%h%h%h flash_active=%b frame_count=%0d",
                 tag, req_at, vga_r, vga_g, vga_b, flash_active, frame_count);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        // ---------------- reset state ----------------
        reset = 1'b1;
        cycle(); cycle();
        chk("rst_hs", 32'(vga_hs), 32'd1);
        chk("rst_vs", 32'(vga_vs), 32'd1);
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_fa", 32'(flash_active), 32'd0);
        reset = 1'b0;
        $display("step reset: hs=%b vs=%b rgb=%h%h%h", vga_hs, vga_vs, vga_r, vga_g, vga_b);

        // ---------------- randomized phase ----------------
        for (int n = 0; n < 1500; n++) begin
            bit tk;
            tk = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 399) == 0);
            drive(tk ? 11'd0 : 11'($urandom_range(1, 1343)),
                  tk ? 10'd768 : 10'($urandom_range(0, 805)),
                  1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom),
                  $urandom_range(0, 23) == 0, 2'($urandom));
        end
        reset = 1'b0;
        $display("step random: 1500 cycles, frame_count=%0d", frame_count);

        // ---------------- alignment ----------------
        reset = 1'b1; cycle(); reset = 1'b0;
        for (int i = 0; i < 21; i++) begin
            drive(11'(1040 + i), 10'd300, (1040 + i) < 1047, 1'b1, 1'b1, 24'($urandom), 1'b0, 2'd0);
            if (i == 9)  chk("align_hs_high", 32'(vga_hs), 32'd1);
            if (i == 10) chk("align_hs_fall", 32'(vga_hs), 32'd0);
        end
        for (int i = 0; i < 21; i++) begin
            drive(11'(5 + i), 10'd301, 1'b1, 1'b1, 1'b0,
                  (i == 8) ? 24'hA5C3E1 : 24'($urandom), 1'b0, 2'd0);
            if (i == 8) begin
                chk("align_px_r", 32'(vga_r), 32'hA);
                chk("align_px_g", 32'(vga_g), 32'hC);
                chk("align_px_b", 32'(vga_b), 32'hE);
            end
        end
        $display("step alignment: done");

        // ---------------- blanking ----------------
        for (int i = 0; i < 12; i++) begin
            drive(11'(1100 + i), 10'd302, 1'b1, 1'b1, 1'b1, 24'hFFFFFF, 1'b0, 2'd0);
            if (i >= D) chk("blank_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        end
        $display("step blanking: rgb=%h%h%h", vga_r, vga_g, vga_b);

        // ---------------- flash ----------------
        reset = 1'b1; cycle(); reset = 1'b0;
        fa_cycles = 0;
        frame("f0", -1, 2'd0, 24'h808080, 4'h8, 4'h8, 4'h8, 1'b0);
        frame("f1", 15, 2'd0, 24'h808080, 4'h8, 4'h8, 4'h8, 1'b0);
        frame("f2", -1, 2'd0, 24'h808080, 4'hB, 4'h4, 4'h4, 1'b1);
        frame("f3", -1, 2'd0, 24'h808080, 4'hB, 4'h4, 4'h4, 1'b1);
        frame("f4", -1, 2'd0, 24'h808080, 4'h8, 4'h8, 4'h8, 1'b0);
        chk("flash_len", 32'(fa_cycles), 32'(2 * FL));

        // ---------------- retrigger ----------------
        frame("r0", 10, 2'd0, 24'h808080, 4'h8, 4'h8, 4'h8, 1'b0);
        frame("r1", 10, 2'd1, 24'h808080, 4'hB, 4'h4, 4'h4, 1'b1);
        frame("r2", -1, 2'd1, 24'h808080, 4'h4, 4'hB, 4'h4, 1'b1);
        frame("r3", -1, 2'd1, 24'h808080, 4'h4, 4'hB, 4'h4, 1'b1);
        frame("r4", -1, 2'd1, 24'h808080, 4'h8, 4'h8, 4'h8, 1'b0);

        // ---------------- reset mid-flash ----------------
        frame("m0", 10, 2'd2, 24'h808080, 4'h8, 4'h8, 4'h8, 1'b0);
        drive(11'd0, 10'd768, 1'b1, 1'b0, 1'b1, 24'h808080, 1'b0, 2'd0);
        for (int i = 1; i < 12; i++) begin
            drive(11'(i), 10'd5, 1'b0, 1'b0, 1'b0, 24'h808080, 1'b0, 2'd0);
        end
        chk("mid_fa_before", 32'(flash_active), 32'd1);
        reset = 1'b1;
        drive(11'd12, 10'd5, 1'b0, 1'b0, 1'b0, 24'h808080, 1'b0, 2'd0);
        reset = 1'b0;
        chk("mid_rst_fa", 32'(flash_active), 32'd0);
        chk("mid_rst_hs", 32'(vga_hs), 32'd1);
        chk("mid_rst_vs", 32'(vga_vs), 32'd1);
        chk("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("mid_rst_fc", 32'(frame_count), 32'd0);
        $display("step reset-mid-flash: fa=%b hs=%b vs=%b fc=%0d", flash_active, vga_hs, vga_vs, frame_count);

        // ---------------- frame counter ----------------
        for (int n = 0; n < 200; n++) begin
            drive(11'd0, 10'd768, 1'b1, 1'b1, 1'b1, 24'd0, 1'b0, 2'd0);
            drive(11'd1, 10'd768, 1'b1, 1'b1, 1'b1, 24'd0, 1'b0, 2'd0);
            drive(11'd0, 10'd769, 1'b1, 1'b1, 1'b1, 24'd0, 1'b0, 2'd0);
        end
        chk("fc_200", 32'(frame_count), 32'd200);
        $display("step frame-count: fc=%0d", frame_count);
        for (int n = 0; n < 65336; n++) begin
            drive(11'd0, 10'd768, 1'b1, 1'b1, 1'b1, 24'd0, 1'b0, 2'd0);
        end
        chk("fc_wrap", 32'(frame_count), 32'd0);
        $display("step frame-count wrap: fc=%0d", frame_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
